// File: rtl/cardinal_nic_fifo_if.sv
// Processor bus and ring-router port of the cardinal NIC, grouped into one bundle.
// slave is the NIC side, master is the processor/router side.
interface cardinal_nic_fifo_if #(
    parameter int PACKET_SIZE = 64
);
    logic                   nicEn;
    logic                   nicWrEn;
    logic [1:0]             addr;
    logic [PACKET_SIZE-1:0] d_in;
    logic [PACKET_SIZE-1:0] d_out;
    logic                   net_si;
    logic                   net_ri;
    logic [PACKET_SIZE-1:0] net_di;
    logic                   net_so;
    logic                   net_ro;
    logic [PACKET_SIZE-1:0] net_do;
    logic                   net_polarity;

    // Handshake: a packet moves on a rising edge where its sender's valid
    // (net_si / net_so) and the receiver's ready (net_ri / net_ro) are both 1.
    modport slave (
        input  nicEn, nicWrEn, addr, d_in, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

    modport master (
        output nicEn, nicWrEn, addr, d_in, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/cardinal_nic_fifo.sv
// Cardinal NIC with DEPTH-entry show-ahead FIFOs per direction and phase-gated injection.
// Define CARDINAL_NIC_OVF_EN to add the sticky output-overflow flag (out-status bit PACKET_SIZE-2).
module cardinal_nic_fifo #(
    parameter int PACKET_SIZE = 64,
    parameter int DEPTH       = 4,
    parameter int VC_BIT      = 0,
    parameter int CNT_W       = $clog2(DEPTH) + 1
) (
    input logic                clk,
    input logic                reset,
    cardinal_nic_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PACKET_SIZE-1:0] out_mem_q [DEPTH];
    logic [PACKET_SIZE-1:0] in_mem_q  [DEPTH];
    logic [PTR_W-1:0]       out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [PTR_W-1:0]       in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d, in_cnt_q, in_cnt_d;

    logic [PACKET_SIZE-1:0] out_head, in_head;
    logic                   out_push, out_pop, in_push, in_pop;
    logic                   wr_out_data, rd_out_stat;
    logic                   net_so_w, net_ri_w;
    logic [PACKET_SIZE-1:0] d_out_w;
    logic                   ovf_flag;

    assign out_head = out_mem_q[out_rd_q];
    assign in_head  = in_mem_q[in_rd_q];

    assign wr_out_data = bus.nicEn && bus.nicWrEn && (bus.addr == 2'b10);
    assign rd_out_stat = bus.nicEn && !bus.nicWrEn && (bus.addr == 2'b11);

    // Full is judged on the registered count only, so a same-cycle pop never
    // opens a slot; net_ri thereby stays independent of the processor bus.
    assign out_push = wr_out_data && (out_cnt_q != FULL_CNT);
    assign net_so_w = !reset && (out_cnt_q != '0) && bus.net_ro
                      && (out_head[VC_BIT] != bus.net_polarity);
    assign out_pop  = net_so_w;

    assign net_ri_w = !reset && (in_cnt_q != FULL_CNT);
    assign in_push  = bus.net_si && net_ri_w;
    assign in_pop   = bus.nicEn && !bus.nicWrEn && (bus.addr == 2'b00) && (in_cnt_q != '0);

    always_comb begin
        out_wr_d  = out_push ? out_wr_q + PTR_W'(1) : out_wr_q;
        out_rd_d  = out_pop  ? out_rd_q + PTR_W'(1) : out_rd_q;
        in_wr_d   = in_push  ? in_wr_q + PTR_W'(1)  : in_wr_q;
        in_rd_d   = in_pop   ? in_rd_q + PTR_W'(1)  : in_rd_q;
        out_cnt_d = out_cnt_q;
        if (out_push && !out_pop)      out_cnt_d = out_cnt_q + CNT_W'(1);
        else if (!out_push && out_pop) out_cnt_d = out_cnt_q - CNT_W'(1);
        in_cnt_d = in_cnt_q;
        if (in_push && !in_pop)        in_cnt_d = in_cnt_q + CNT_W'(1);
        else if (!in_push && in_pop)   in_cnt_d = in_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_cnt_q  <= '0;
        end else begin
            out_wr_q  <= out_wr_d;
            out_rd_q  <= out_rd_d;
            out_cnt_q <= out_cnt_d;
            in_wr_q   <= in_wr_d;
            in_rd_q   <= in_rd_d;
            in_cnt_q  <= in_cnt_d;
        end
    end

    // Storage needs no reset: an entry is only visible once its count covers it.
    always_ff @(posedge clk) begin
        if (!reset && out_push) out_mem_q[out_wr_q] <= bus.d_in;
        if (!reset && in_push)  in_mem_q[in_wr_q]   <= bus.net_di;
    end

`ifdef CARDINAL_NIC_OVF_EN
    logic out_ovf_q, out_ovf_d;

    always_comb begin
        out_ovf_d = out_ovf_q;
        if (wr_out_data && (out_cnt_q == FULL_CNT)) out_ovf_d = 1'b1;
        else if (rd_out_stat)                       out_ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) out_ovf_q <= 1'b0;
        else       out_ovf_q <= out_ovf_d;
    end

    assign ovf_flag = out_ovf_q;
`else
    assign ovf_flag = 1'b0;
`endif

    always_comb begin
        d_out_w = '0;
        if (bus.nicEn && !bus.nicWrEn) begin
            case (bus.addr)
                2'b00: if (in_cnt_q != '0) d_out_w = in_head;
                2'b01: begin
                    d_out_w[PACKET_SIZE-1] = (in_cnt_q != '0);
                    d_out_w[CNT_W-1:0]     = in_cnt_q;
                end
                2'b11: begin
                    d_out_w[PACKET_SIZE-1] = (out_cnt_q == FULL_CNT);
                    d_out_w[PACKET_SIZE-2] = ovf_flag;
                    d_out_w[CNT_W-1:0]     = out_cnt_q;
                end
                default: d_out_w = '0;
            endcase
        end
    end

    assign bus.d_out  = d_out_w;
    assign bus.net_so = net_so_w;
    assign bus.net_ri = net_ri_w;
    assign bus.net_do = net_so_w ? out_head : '0;
endmodule

// File: doc/cardinal_nic_fifo.md
Name: cardinal_nic_fifo

Overview:
Parametrised network interface controller between a processor and one ring router port. It has two independent FIFOs. The output FIFO carries processor-to-network traffic; the input FIFO carries network-to-processor traffic. Each FIFO is DEPTH entries deep, where the previous generation had a single entry per direction. Packets are injected only in the ring phase that matches the packet's virtual-channel bit.

Parameters:
PACKET_SIZE, 64, packet and processor data width in bits (>=16).
DEPTH, 4, entries per FIFO; a power of 2, >=2.
VC_BIT, 0, index of the packet bit compared against net_polarity.
CNT_W, $clog2(DEPTH)+1, occupancy counter width; derived, not to be overridden.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  reset, synchronous, active-high
nicEn  in  1  processor access enable
nicWrEn  in  1  1=write, 0=read (valid when nicEn=1)
addr  in  2  00 in-data, 01 in-status, 10 out-data, 11 out-status
d_in  in  PACKET_SIZE  processor write data
d_out  out  PACKET_SIZE  processor read data (combinational)
net_si  in  1  router sends packet to NIC
net_ri  out  1  NIC ready to receive
net_di  in  PACKET_SIZE  router packet in
net_so  out  1  NIC sends packet to router
net_ro  in  1  router ready to accept
net_do  out  PACKET_SIZE  packet to router
net_polarity  in  1  current ring phase

Behaviour:
- Reset (synchronous): clears both FIFO pointers and counts to 0. During reset net_so=0, net_ri=0, net_do=0. d_out follows the decode rules below.
- FIFOs are show-ahead: the head entry is visible combinationally. Push and pop occur at the clock edge.
- Processor write: when nicEn=1, nicWrEn=1 and addr=10:
  - If out_count<DEPTH, push d_in.
  - If full, drop the write silently, even if a pop happens in the same cycle. A write to any other address has no effect.
- Processor read, in-data: nicEn=1, nicWrEn=0, addr=00.
  - d_out = input head if in_count>0, else 0.
  - Pop at the edge only if non-empty. Reading an empty FIFO returns 0 with no state change.
- Processor read, in-status (addr=01): d_out[PACKET_SIZE-1] = (in_count>0); d_out[CNT_W-1:0] = in_count; all other bits 0.
- Processor read, out-status (addr=11): d_out[PACKET_SIZE-1] = (out_count==DEPTH); d_out[CNT_W-1:0] = out_count; all other bits 0.
- Read of addr=10, or nicEn=0: d_out = 0.
- Injection: net_so = !reset & out_count>0 & net_ro & (out_head[VC_BIT] != net_polarity).
  - net_do = out_head when net_so=1, else 0.
  - The output FIFO pops at the edge when net_so=1.
  - A packet with the wrong phase blocks the head (no reordering) until the polarity toggles.
- Ejection: net_ri = !reset & (in_count<DEPTH).
  - Push net_di when net_si & net_ri.
  - A full FIFO deasserts net_ri even if the processor pops in the same cycle. This gives one bubble; it is deliberate and keeps net_ri free of any path from nicEn/addr.
- Simultaneous push and pop on the same FIFO when neither is blocked: both happen and the count is unchanged. Pointers wrap modulo DEPTH.

Optional Feature:
Macro: CARDINAL_NIC_OVF_EN.
- Enabled: a sticky out_ovf flag sets when a processor write to addr=10 is dropped because the FIFO is full.
  - It reads as d_out[PACKET_SIZE-2] on an addr=11 read.
  - The flag clears at the edge of that read, unless a new drop occurs in the same cycle, in which case it stays set.
  - Reset clears it.
- Disabled: no flag exists and d_out[PACKET_SIZE-2] always reads 0.

Test Plan:
- Reset, then read addr 01 and 11 -> d_out=0 for both; net_ri=1 and net_so=0 after reset drops.
- With DEPTH=4, net_ro=0, write 0xA0,0xA2,0xA4,0xA6,0xA8 to addr 10 -> addr 11 reads MSB=1, count=4; 0xA8 dropped (out_ovf=1 if enabled, cleared on the second read).
- Same FIFO, net_ro=1, polarity toggles each cycle, VC_BIT=0 -> net_so only in polarity=1 cycles; net_do sequence 0xA0,0xA2,0xA4,0xA6; count returns to 0.
- Head=0x01 with polarity held at 1 -> net_so stays 0 for 10 cycles; polarity goes to 0 -> sent next cycle.
- Router pushes 5 packets with net_si=1, no processor reads -> net_ri drops after 4 accepted; addr 00 reads return them in order; the 5th is offered again once net_ri=1.
- Assert reset with 3 entries in each FIFO -> both counts read 0 next cycle; addr 00 read returns 0.
